// File: rtl/hub75_panel_rx_capture.sv
// HUB75 receive-side capture: deserializes shifted columns, holds the plane on latch,
// measures unblanked time and streams one beat per column. Row-sequence checking: HUB75_RX_ROWCHECK_EN.
module hub75_panel_rx_capture #(
  parameter int COLS        = 64,
  parameter int ROW_BITS    = 5,
  parameter int ONTIME_W    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [5:0]               hub_rgb,
  input  logic [ROW_BITS-1:0]      hub_a,
  input  logic                     hub_blank,
  input  logic                     hub_sclk,
  input  logic                     hub_latch,
  input  logic                     clear_status,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ROW_BITS-1:0]      out_row,
  output logic [$clog2(COLS)-1:0]  out_col,
  output logic [5:0]               out_rgb,
  output logic                     out_last,
  output logic [ONTIME_W-1:0]      out_ontime,
  output logic                     out_shift_err,
  output logic                     overflow,
  output logic                     row_err
);

  localparam int COL_W = $clog2(COLS);
  localparam int SC_W  = $clog2(COLS + 2);
  localparam int IN_W  = 6 + ROW_BITS + 3;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_LATCHED = 2'd1;
  localparam logic [1:0] S_EMIT    = 2'd2;

  logic [IN_W-1:0]     sync_q [SYNC_STAGES];
  logic [5:0]          rgb_s;
  logic [ROW_BITS-1:0] a_s;
  logic                blank_s, sclk_s, latch_s;
  logic                sclk_prev_q, latch_prev_q, blank_prev_q;
  logic                sclk_rise, latch_rise, blank_rise;

  logic [5:0]          sr_q   [COLS];
  logic [5:0]          hold_q [COLS];
  logic [1:0]          state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ONTIME_W-1:0] ontime_q, ontime_d;
  logic                seen_q, seen_d;
  logic [ROW_BITS-1:0] hold_row_q, hold_row_d;
  logic                hold_err_q, hold_err_d;
  logic [SC_W-1:0]     shift_cnt_q, shift_cnt_d;
  logic                overflow_q, ovf_set, capture;

  // All hub inputs share one chain so data and strobes stay aligned after synchronization.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      sclk_prev_q  <= 1'b0;
      latch_prev_q <= 1'b0;
      blank_prev_q <= 1'b0;
    end else begin
      sync_q[0] <= {hub_rgb, hub_a, hub_blank, hub_sclk, hub_latch};
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      sclk_prev_q  <= sclk_s;
      latch_prev_q <= latch_s;
      blank_prev_q <= blank_s;
    end
  end

  assign {rgb_s, a_s, blank_s, sclk_s, latch_s} = sync_q[SYNC_STAGES-1];
  assign sclk_rise  = sclk_s  & ~sclk_prev_q;
  assign latch_rise = latch_s & ~latch_prev_q;
  assign blank_rise = blank_s & ~blank_prev_q;

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    ontime_d    = ontime_q;
    seen_d      = seen_q;
    hold_row_d  = hold_row_q;
    hold_err_d  = hold_err_q;
    ovf_set     = 1'b0;
    capture     = 1'b0;
    case (state_q)
      S_IDLE: capture = latch_rise;
      S_LATCHED: begin
        // A blank rise that ends a lit plane beats a simultaneous latch.
        if (blank_rise && seen_q) begin
          state_d = S_EMIT;
          col_d   = '0;
          ovf_set = latch_rise;
        end else if (latch_rise) begin
          capture = 1'b1;
        end else if (!blank_s) begin
          seen_d = 1'b1;
          if (ontime_q != {ONTIME_W{1'b1}}) ontime_d = ontime_q + ONTIME_W'(1);
        end
      end
      S_EMIT: begin
        ovf_set = latch_rise;
        if (out_ready) begin
          if (col_q == COL_W'(COLS - 1)) state_d = S_IDLE;
          else                           col_d   = col_q + COL_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (capture) begin
      state_d    = S_LATCHED;
      hold_row_d = a_s;
      hold_err_d = (shift_cnt_q != SC_W'(COLS));
      ontime_d   = '0;
      seen_d     = 1'b0;
    end
    shift_cnt_d = shift_cnt_q;
    if (latch_rise)                                      shift_cnt_d = '0;
    else if (sclk_rise && shift_cnt_q != SC_W'(COLS + 1)) shift_cnt_d = shift_cnt_q + SC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      ontime_q    <= '0;
      seen_q      <= 1'b0;
      hold_row_q  <= '0;
      hold_err_q  <= 1'b0;
      shift_cnt_q <= '0;
      overflow_q  <= 1'b0;
      for (int i = 0; i < COLS; i++) begin
        sr_q[i]   <= '0;
        hold_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      ontime_q    <= ontime_d;
      seen_q      <= seen_d;
      hold_row_q  <= hold_row_d;
      hold_err_q  <= hold_err_d;
      shift_cnt_q <= shift_cnt_d;
      overflow_q  <= (overflow_q & ~clear_status) | ovf_set;
      if (sclk_rise) begin
        for (int i = 0; i < COLS - 1; i++) sr_q[i] <= sr_q[i+1];
        sr_q[COLS-1] <= rgb_s;
      end
      if (capture) begin
        for (int i = 0; i < COLS; i++) hold_q[i] <= sr_q[i];
      end
    end
  end

`ifdef HUB75_RX_ROWCHECK_EN
  logic [ROW_BITS-1:0] last_row_q;
  logic                have_row_q, row_err_q, row_bad;

  // Rows may repeat (multi-plane PWM) or advance by one; anything else is a sequence error.
  assign row_bad = capture && have_row_q && (a_s != last_row_q) &&
                   (a_s != last_row_q + ROW_BITS'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_row_q <= '0;
      have_row_q <= 1'b0;
      row_err_q  <= 1'b0;
    end else begin
      if (capture) begin
        last_row_q <= a_s;
        have_row_q <= 1'b1;
      end
      row_err_q <= (row_err_q & ~clear_status) | row_bad;
    end
  end
  assign row_err = row_err_q;
`else
  assign row_err = 1'b0;
`endif

  assign overflow      = overflow_q;
  assign out_valid     = (state_q == S_EMIT);
  assign out_col       = col_q;
  assign out_rgb       = hold_q[col_q];
  assign out_last      = (col_q == COL_W'(COLS - 1));
  assign out_row       = hold_row_q;
  assign out_ontime    = ontime_q;
  assign out_shift_err = hold_err_q;

endmodule

// File: tb/tb_hub75_panel_rx_capture.sv
// Scoreboard bench for hub75_panel_rx_capture: directed planes, stalls, overflow, reset, row check.
module tb_hub75_panel_rx_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  hub_rgb;
  logic [4:0]  hub_a;
  logic        hub_blank, hub_sclk, hub_latch, clear_status;
  logic        out_valid, out_ready;
  logic [4:0]  out_row;
  logic [5:0]  out_col, out_rgb;
  logic        out_last;
  logic [15:0] out_ontime;
  logic        out_shift_err, overflow, row_err;

  typedef struct packed {
    logic [4:0]  row;
    logic [5:0]  col;
    logic [5:0]  rgb;
    logic        last;
    logic [15:0] ontime;
    logic        err;
  } beat_t;

  beat_t      sb[$];
  logic [5:0] model_sr [64];
  int         tests = 0;
  int         fails = 0;
  int         rdy_mode = 0;

  hub75_panel_rx_capture dut (
    .clk(clk), .rst_n(rst_n), .hub_rgb(hub_rgb), .hub_a(hub_a), .hub_blank(hub_blank),
    .hub_sclk(hub_sclk), .hub_latch(hub_latch), .clear_status(clear_status),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_col(out_col),
    .out_rgb(out_rgb), .out_last(out_last), .out_ontime(out_ontime),
    .out_shift_err(out_shift_err), .overflow(overflow), .row_err(row_err)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic shift_cols(input int n, input int base, input int step);
    logic [5:0] v;
    for (int j = 0; j < n; j++) begin
      v = 6'((base + j * step) & 63);
      hub_rgb  = v;
      hub_sclk = 1'b0;
      cyc(2);
      hub_sclk = 1'b1;
      cyc(2);
      for (int i = 0; i < 63; i++) model_sr[i] = model_sr[i+1];
      model_sr[63] = v;
    end
    hub_sclk = 1'b0;
    cyc(2);
  endtask

  task automatic do_latch(input logic [4:0] a);
    hub_a     = a;
    hub_latch = 1'b1;
    cyc(3);
    hub_latch = 1'b0;
    cyc(3);
  endtask

  task automatic push_record(input logic [4:0] row, input logic [15:0] ontime, input logic err);
    beat_t b;
    for (int c = 0; c < 64; c++) begin
      b.row = row; b.col = 6'(c); b.rgb = model_sr[c];
      b.last = (c == 63); b.ontime = ontime; b.err = err;
      sb.push_back(b);
    end
  endtask

  task automatic unblank(input int n);
    hub_blank = 1'b0;
    cyc(n);
    hub_blank = 1'b1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 3000; i++) begin
      if (sb.size() == 0 && !out_valid) break;
      cyc(1);
    end
    chk(name, 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 300; i++) begin
      if (out_valid) break;
      cyc(1);
    end
    chk(name, 32'(out_valid), 32'd1);
  endtask

  // Ready pattern generator: 0 = always ready, 1 = alternate, 2 = stalled.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: every presented beat must match the scoreboard head, including while stalled.
  initial begin
    beat_t act;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_beat col=%0d rgb=%0h", out_col, out_rgb);
        end else begin
          act = '{row: out_row, col: out_col, rgb: out_rgb, last: out_last,
                  ontime: out_ontime, err: out_shift_err};
          if (act !== sb[0]) begin
            fails++;
            $display("FAIL beat actual=%h required=%h", act, sb[0]);
          end
          if (out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_row;
    rst_n = 1'b0; hub_rgb = '0; hub_a = '0; hub_blank = 1'b1;
    hub_sclk = 1'b0; hub_latch = 1'b0; clear_status = 1'b0;
    for (int i = 0; i < 64; i++) model_sr[i] = '0;

    // Reset held while inputs toggle.
    for (int k = 0; k < 8; k++) begin
      cyc(1);
      hub_rgb = 6'($urandom); hub_a = 5'($urandom); hub_sclk = ~hub_sclk;
      hub_latch = ~hub_latch; hub_blank = ~hub_blank; clear_status = ~clear_status;
      @(negedge clk);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_row_err", 32'(row_err), 32'd0);
    end
    cyc(1);
    hub_sclk = 1'b0; hub_latch = 1'b0; hub_blank = 1'b1; clear_status = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(5);

    // Full plane, ready always high.
    rdy_mode = 0;
    shift_cols(64, 0, 1);
    do_latch(5'd5);
    push_record(5'd5, 16'd959, 1'b0);
    unblank(959);
    drain("drain_plane");

    // Same plane with alternating ready.
    rdy_mode = 1;
    shift_cols(64, 0, 1);
    do_latch(5'd5);
    push_record(5'd5, 16'd959, 1'b0);
    unblank(959);
    drain("drain_stall");
    rdy_mode = 0;

    // Short line of 63 columns flags a shift error.
    shift_cols(63, 7, 1);
    do_latch(5'd6);
    push_record(5'd6, 16'd300, 1'b1);
    unblank(300);
    drain("drain_short");

    // Latch during a stalled emission: overflow, first record preserved.
    rdy_mode = 2;
    shift_cols(64, 10, 3);
    do_latch(5'd9);
    push_record(5'd9, 16'd100, 1'b0);
    unblank(100);
    wait_valid("emit_start");
    chk("ovf_before", 32'(overflow), 32'd0);
    shift_cols(64, 40, 5);
    do_latch(5'd12);
    chk("ovf_set", 32'(overflow), 32'd1);
    rdy_mode = 0;
    drain("drain_ovf");
    chk("ovf_sticky", 32'(overflow), 32'd1);
    clear_status = 1'b1;
    cyc(1);
    clear_status = 1'b0;
    cyc(1);
    chk("ovf_clear", 32'(overflow), 32'd0);

    // Reset mid-record abandons it.
    rdy_mode = 2;
    shift_cols(64, 3, 1);
    do_latch(5'd2);
    push_record(5'd2, 16'd50, 1'b0);
    unblank(50);
    wait_valid("emit_before_rst");
    rst_n = 1'b0;
    cyc(1);
    sb.delete();
    chk("valid_after_rst", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) model_sr[i] = '0;
    rdy_mode = 0;
    cyc(30);
    chk("no_beats_after_rst", 32'(out_valid), 32'd0);

    // Row sequence 3,3,4,7.
    do_latch(5'd3);
    chk("row_err_3", 32'(row_err), 32'd0);
    do_latch(5'd3);
    chk("row_err_3b", 32'(row_err), 32'd0);
    do_latch(5'd4);
    chk("row_err_4", 32'(row_err), 32'd0);
    do_latch(5'd7);
`ifdef HUB75_RX_ROWCHECK_EN
    exp_row = 32'd1;
`else
    exp_row = 32'd0;
`endif
    chk("row_err_7", 32'(row_err), exp_row);
    clear_status = 1'b1;
    cyc(1);
    clear_status = 1'b0;
    cyc(1);
    chk("row_err_clear", 32'(row_err), 32'd0);
    cyc(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
